// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: core fetch port and debug/loader port share one memory.
// Fixed priority with starvation guard by default; IMEM_ARB_RR_EN selects round-robin.
module imem_arbiter #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    owner_e      owner_q;
    owner_e      owner_d;
    logic        pick_core;
    logic        pick_dbg;
    logic        gnt_core;
    logic        gnt_dbg;
    logic [31:0] addr_q;

`ifdef IMEM_ARB_RR_EN
    owner_e last_gnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= OWN_DBG;
        end else if (gnt_core) begin
            last_gnt_q <= OWN_CORE;
        end else if (gnt_dbg) begin
            last_gnt_q <= OWN_DBG;
        end
    end

    // On contention the port that did not win last time goes first.
    always_comb begin
        pick_core = core_req && (!dbg_req || (last_gnt_q == OWN_DBG));
        pick_dbg  = dbg_req && !pick_core;
    end
`else
    localparam int CW_RAW = $clog2(STARVE_MAX + 1);
    localparam int CW     = (CW_RAW > 3) ? CW_RAW : 3;

    logic [CW-1:0] starve_q;
    logic          starved;

    assign starved = (starve_q == CW'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!dbg_req || gnt_dbg) begin
            starve_q <= '0;
        end else if (gnt_core && (starve_q != '1)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // Core wins unless the debug port has waited through STARVE_MAX core grants.
    always_comb begin
        pick_core = core_req && !(dbg_req && starved);
        pick_dbg  = dbg_req && !pick_core;
    end
`endif

    assign gnt_core = rst_n && pick_core;
    assign gnt_dbg  = rst_n && pick_dbg;

    assign core_gnt = gnt_core;
    assign dbg_gnt  = gnt_dbg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        unique case (1'b1)
            gnt_core: owner_d = OWN_CORE;
            gnt_dbg:  owner_d = OWN_DBG;
            default:  owner_d = OWN_NONE;
        endcase
    end

    always_comb begin
        core_rvalid = (owner_q == OWN_CORE);
        dbg_rvalid  = (owner_q == OWN_DBG);
        core_rdata  = core_rvalid ? mem_instr : 32'h0;
        dbg_rdata   = dbg_rvalid ? mem_instr : 32'h0;
    end

    // Address is forwarded live on a grant and held between grants.
    always_comb begin
        mem_rd   = gnt_core || gnt_dbg;
        mem_addr = addr_q;
        if (gnt_core) begin
            mem_addr = core_addr;
        end else if (gnt_dbg) begin
            mem_addr = dbg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 32'h0;
        end else if (mem_rd) begin
            addr_q <= mem_addr;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference of the arbitration rules.
module tb_imem_arbiter;

    localparam int SM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic [31:0] core_addr = 32'h0;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_addr = 32'h0;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr = 32'h0;

    imem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_addr(core_addr),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_instr(mem_instr)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [0:1023];

    // Memory returns garbage when not read so rdata gating is exercised.
    always @(posedge clk) mem_instr <= mem_rd ? imem[mem_addr[11:2]] : $urandom;

    int nvec = 0;
    int nerr = 0;

    // Reference state: who owns next data phase, its address, held address,
    // consecutive core wins while dbg waits, last winner (1 core, 2 dbg).
    int          m_owner;
    logic [31:0] m_paddr;
    logic [31:0] m_last;
    int          m_wait;
    int          m_rr_last;

    logic        e_cg, e_dg, e_rd, e_crv, e_drv;
    logic [31:0] e_addr, e_crd, e_drd;

    task automatic model_reset();
        m_owner = 0;
        m_paddr = 32'h0;
        m_last = 32'h0;
        m_wait = 0;
        m_rr_last = 2;
    endtask

    task automatic predict();
        if (core_req && dbg_req) begin
`ifdef IMEM_ARB_RR_EN
            e_cg = (m_rr_last == 2);
`else
            e_cg = (m_wait < SM);
`endif
            e_dg = !e_cg;
        end else begin
            e_cg = core_req;
            e_dg = dbg_req;
        end
        e_rd = e_cg || e_dg;
        e_addr = e_cg ? core_addr : (e_dg ? dbg_addr : m_last);
        e_crv = (m_owner == 1);
        e_drv = (m_owner == 2);
        e_crd = e_crv ? imem[m_paddr[11:2]] : 32'h0;
        e_drd = e_drv ? imem[m_paddr[11:2]] : 32'h0;
    endtask

    task automatic commit();
        m_owner = e_cg ? 1 : (e_dg ? 2 : 0);
        if (e_rd) m_paddr = e_addr;
        m_last = e_addr;
        if (!dbg_req || e_dg) m_wait = 0;
        else if (e_cg && m_wait < SM) m_wait = m_wait + 1;
        if (e_cg) m_rr_last = 1;
        else if (e_dg) m_rr_last = 2;
    endtask

    task automatic drive(input logic c, input logic [31:0] ca,
                         input logic d, input logic [31:0] da);
        core_req = c;
        core_addr = ca;
        dbg_req = d;
        dbg_addr = da;
        #1;
        predict();
    endtask

    task automatic tick();
        commit();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = 32'h0100_0000 | ($urandom & 32'h0000_0FFC);
        return a;
    endfunction

    task automatic test_reset();
        core_req = 1'b1;
        dbg_req = 1'b1;
        core_addr = $urandom;
        dbg_addr = $urandom;
        #3;
        nvec++; if (core_gnt !== 1'b0) begin nerr++; $display("FAIL reset core_gnt got %b want 0", core_gnt); end
        nvec++; if (dbg_gnt !== 1'b0) begin nerr++; $display("FAIL reset dbg_gnt got %b want 0", dbg_gnt); end
        nvec++; if (mem_rd !== 1'b0) begin nerr++; $display("FAIL reset mem_rd got %b want 0", mem_rd); end
        nvec++; if (mem_addr !== 32'h0) begin nerr++; $display("FAIL reset mem_addr got %h want 0", mem_addr); end
        nvec++; if (core_rvalid !== 1'b0) begin nerr++; $display("FAIL reset core_rvalid got %b want 0", core_rvalid); end
        nvec++; if (dbg_rvalid !== 1'b0) begin nerr++; $display("FAIL reset dbg_rvalid got %b want 0", dbg_rvalid); end
        nvec++; if (core_rdata !== 32'h0) begin nerr++; $display("FAIL reset core_rdata got %h want 0", core_rdata); end
        nvec++; if (dbg_rdata !== 32'h0) begin nerr++; $display("FAIL reset dbg_rdata got %h want 0", dbg_rdata); end
        core_req = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_core_burst();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0100_0000 + 32'(4 * i);
            if (i < 3) drive(1'b1, a, 1'b0, 32'h0);
            else drive(1'b0, 32'h0, 1'b0, 32'h0);
            nvec++; if (core_gnt !== (i < 3)) begin nerr++; $display("FAIL burst core_gnt[%0d] got %b want %b", i, core_gnt, i < 3); end
            nvec++; if (dbg_gnt !== 1'b0) begin nerr++; $display("FAIL burst dbg_gnt[%0d] got %b want 0", i, dbg_gnt); end
            if (i < 3) begin
                nvec++; if (mem_addr !== a) begin nerr++; $display("FAIL burst mem_addr[%0d] got %h want %h", i, mem_addr, a); end
            end else begin
                nvec++; if (mem_addr !== 32'h0100_0008) begin nerr++; $display("FAIL burst hold mem_addr got %h want 01000008", mem_addr); end
                nvec++; if (mem_rd !== 1'b0) begin nerr++; $display("FAIL burst idle mem_rd got %b want 0", mem_rd); end
            end
            nvec++; if (core_rvalid !== (i > 0)) begin nerr++; $display("FAIL burst core_rvalid[%0d] got %b want %b", i, core_rvalid, i > 0); end
            if (i > 0) begin
                nvec++; if (core_rdata !== imem[i-1]) begin nerr++; $display("FAIL burst core_rdata[%0d] got %h want %h", i, core_rdata, imem[i-1]); end
            end
            nvec++; if (dbg_rvalid !== 1'b0) begin nerr++; $display("FAIL burst dbg_rvalid[%0d] got %b want 0", i, dbg_rvalid); end
            tick();
        end
    endtask

    task automatic test_dbg_top();
        drive(1'b0, 32'h0, 1'b1, 32'h0100_0FFC);
        nvec++; if (dbg_gnt !== 1'b1) begin nerr++; $display("FAIL dbgtop dbg_gnt got %b want 1", dbg_gnt); end
        nvec++; if (mem_addr !== 32'h0100_0FFC) begin nerr++; $display("FAIL dbgtop mem_addr got %h want 01000ffc", mem_addr); end
        nvec++; if (mem_rd !== 1'b1) begin nerr++; $display("FAIL dbgtop mem_rd got %b want 1", mem_rd); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        nvec++; if (dbg_rvalid !== 1'b1) begin nerr++; $display("FAIL dbgtop dbg_rvalid got %b want 1", dbg_rvalid); end
        nvec++; if (dbg_rdata !== imem[1023]) begin nerr++; $display("FAIL dbgtop dbg_rdata got %h want %h", dbg_rdata, imem[1023]); end
        nvec++; if (core_rvalid !== 1'b0) begin nerr++; $display("FAIL dbgtop core_rvalid got %b want 0", core_rvalid); end
        tick();
    endtask

    task automatic test_contention();
        logic want_dbg;
        for (int i = 0; i < 2 * (SM + 1); i++) begin
            drive(1'b1, rnd_addr(), 1'b1, rnd_addr());
`ifdef IMEM_ARB_RR_EN
            want_dbg = (i % 2 == 1);
`else
            want_dbg = (i % (SM + 1) == SM);
`endif
            nvec++; if (dbg_gnt !== want_dbg) begin nerr++; $display("FAIL contend dbg_gnt[%0d] got %b want %b", i, dbg_gnt, want_dbg); end
            nvec++; if (core_gnt !== !want_dbg) begin nerr++; $display("FAIL contend core_gnt[%0d] got %b want %b", i, core_gnt, !want_dbg); end
            nvec++; if (mem_addr !== e_addr) begin nerr++; $display("FAIL contend mem_addr[%0d] got %h want %h", i, mem_addr, e_addr); end
            tick();
        end
    endtask

    task automatic test_handover();
        logic [31:0] b;
        b = rnd_addr();
        drive(1'b1, 32'h0100_0010, 1'b0, 32'h0);
        nvec++; if (core_gnt !== 1'b1) begin nerr++; $display("FAIL handover core_gnt got %b want 1", core_gnt); end
        tick();
        drive(1'b0, 32'h0100_0014, 1'b1, b);
        nvec++; if (dbg_gnt !== 1'b1) begin nerr++; $display("FAIL handover dbg_gnt got %b want 1", dbg_gnt); end
        nvec++; if (core_gnt !== 1'b0) begin nerr++; $display("FAIL handover core_gnt2 got %b want 0", core_gnt); end
        nvec++; if (mem_addr !== b) begin nerr++; $display("FAIL handover mem_addr got %h want %h", mem_addr, b); end
        nvec++; if (core_rdata !== imem[4]) begin nerr++; $display("FAIL handover core_rdata got %h want %h", core_rdata, imem[4]); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 32'h0100_0020, 1'b1, 32'h0100_0024);
        #1;
        rst_n = 1'b0;
        #1;
        nvec++; if (core_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin nerr++; $display("FAIL rstfly gnt got %b%b want 00", core_gnt, dbg_gnt); end
        nvec++; if (mem_rd !== 1'b0 || mem_addr !== 32'h0) begin nerr++; $display("FAIL rstfly mem got %b/%h want 0/0", mem_rd, mem_addr); end
        model_reset();
        core_req = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom, 1'b0, $urandom);
            nvec++; if (core_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin nerr++; $display("FAIL rstfly rvalid[%0d] got %b%b want 00", i, core_rvalid, dbg_rvalid); end
            nvec++; if (core_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin nerr++; $display("FAIL rstfly rdata[%0d] got %h/%h want 0", i, core_rdata, dbg_rdata); end
            nvec++; if (mem_rd !== 1'b0 || mem_addr !== 32'h0) begin nerr++; $display("FAIL rstfly idle[%0d] got %b/%h want 0/0", i, mem_rd, mem_addr); end
            nvec++; if (core_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin nerr++; $display("FAIL rstfly gnt[%0d] got %b%b want 00", i, core_gnt, dbg_gnt); end
            tick();
        end
    endtask

    task automatic test_random();
        logic c, d;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 9) < 6);
            drive(c, rnd_addr(), d, rnd_addr());
            nvec++; if (core_gnt !== e_cg) begin nerr++; $display("FAIL rnd core_gnt[%0d] got %b want %b", i, core_gnt, e_cg); end
            nvec++; if (dbg_gnt !== e_dg) begin nerr++; $display("FAIL rnd dbg_gnt[%0d] got %b want %b", i, dbg_gnt, e_dg); end
            nvec++; if (mem_rd !== e_rd) begin nerr++; $display("FAIL rnd mem_rd[%0d] got %b want %b", i, mem_rd, e_rd); end
            nvec++; if (mem_addr !== e_addr) begin nerr++; $display("FAIL rnd mem_addr[%0d] got %h want %h", i, mem_addr, e_addr); end
            nvec++; if (core_rvalid !== e_crv) begin nerr++; $display("FAIL rnd core_rvalid[%0d] got %b want %b", i, core_rvalid, e_crv); end
            nvec++; if (core_rdata !== e_crd) begin nerr++; $display("FAIL rnd core_rdata[%0d] got %h want %h", i, core_rdata, e_crd); end
            nvec++; if (dbg_rvalid !== e_drv) begin nerr++; $display("FAIL rnd dbg_rvalid[%0d] got %b want %b", i, dbg_rvalid, e_drv); end
            nvec++; if (dbg_rdata !== e_drd) begin nerr++; $display("FAIL rnd dbg_rdata[%0d] got %h want %h", i, dbg_rdata, e_drd); end
            nvec++; if (core_gnt === 1'b1 && dbg_gnt === 1'b1) begin nerr++; $display("FAIL rnd dual_gnt[%0d] got 11 want at most one", i); end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        model_reset();
        test_reset();
        test_core_burst();
        test_dbg_top();
        test_contention();
        test_handover();
        test_reset_inflight();
        test_random();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
